// File: rtl/ram_arbiter_if.sv
// Requester-side bus for ram_arbiter: one instance per requester port.
// The master modport is the requester view; the slave modport is the arbiter view.
interface ram_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// Zero-fills the RAM after reset, then issues one registered access per cycle.
module ram_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter bit          INIT_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ram_arbiter_if.slave      m0_if,
    ram_arbiter_if.slave      m1_if,
    output logic              ram_cs_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic              init_done_o
);

    typedef enum logic {StInit, StRun} state_e;

    // Extra counter bit gives one idle INIT cycle after the last fill write.
    localparam logic [ADDR_W:0] FillEnd = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CntOne  = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q;
    logic [ADDR_W:0]   fill_cnt_q;
    logic              last_q;
    logic              rd_pend_q;
    logic              rd_tag_q;
    logic              rsp_valid_q;
    logic              rsp_tag_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              run;
    logic              gnt0;
    logic              gnt1;
    logic              acc;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        run       = (state_q == StRun);
        gnt0      = run & m0_if.req & (~m1_if.req | last_q);
        gnt1      = run & m1_if.req & (~m0_if.req | ~last_q);
        acc       = gnt0 | gnt1;
        sel_we    = gnt1 ? m1_if.we    : m0_if.we;
        sel_addr  = gnt1 ? m1_if.addr  : m0_if.addr;
        sel_wdata = gnt1 ? m1_if.wdata : m0_if.wdata;
    end

    always_comb begin
        init_done_o   = run;
        m0_if.gnt     = gnt0;
        m1_if.gnt     = gnt1;
        m0_if.rvalid  = rsp_valid_q & ~rsp_tag_q;
        m1_if.rvalid  = rsp_valid_q & rsp_tag_q;
        m0_if.rdata   = (rsp_valid_q & ~rsp_tag_q) ? ram_data_i : rdata0_q;
        m1_if.rdata   = (rsp_valid_q & rsp_tag_q) ? ram_data_i : rdata1_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INIT_EN ? StInit : StRun;
            fill_cnt_q  <= '0;
            last_q      <= 1'b1;
            ram_cs_o    <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_data_o  <= '0;
            rd_pend_q   <= 1'b0;
            rd_tag_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            // Tag travels with the RAM cycle so the response reaches its issuer.
            rd_pend_q   <= acc & ~sel_we;
            rd_tag_q    <= gnt1;
            rsp_valid_q <= rd_pend_q;
            rsp_tag_q   <= rd_tag_q;
            if (rsp_valid_q & ~rsp_tag_q) rdata0_q <= ram_data_i;
            if (rsp_valid_q & rsp_tag_q)  rdata1_q <= ram_data_i;

            ram_cs_o <= 1'b0;
            ram_we_o <= 1'b0;
            unique case (state_q)
                StInit: begin
                    if (fill_cnt_q == FillEnd) begin
                        state_q <= StRun;
                    end else begin
                        ram_cs_o   <= 1'b1;
                        ram_we_o   <= 1'b1;
                        ram_addr_o <= fill_cnt_q[ADDR_W-1:0];
                        ram_data_o <= '0;
                        fill_cnt_q <= fill_cnt_q + CntOne;
                    end
                end
                StRun: begin
                    if (acc) begin
                        ram_cs_o   <= 1'b1;
                        ram_we_o   <= sel_we;
                        ram_addr_o <= sel_addr;
                        ram_data_o <= sel_wdata;
                        last_q     <= gnt1;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 256x32 single-port RAM.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_cs;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic        init_done;
    logic [31:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    ram_arbiter_if #(.ADDR_W(8), .DATA_W(32)) m0_if ();
    ram_arbiter_if #(.ADDR_W(8), .DATA_W(32)) m1_if ();

    ram_arbiter #(.ADDR_W(8), .DATA_W(32), .INIT_EN(1'b1)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m0_if      (m0_if),
        .m1_if      (m1_if),
        .ram_cs_o   (ram_cs),
        .ram_we_o   (ram_we),
        .ram_addr_o (ram_addr),
        .ram_data_o (ram_wdata),
        .ram_data_i (ram_rdata),
        .init_done_o(init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
        else if (ram_cs)      ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.addr = 8'h0; m0_if.wdata = 32'h0;
        m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = 8'h0; m1_if.wdata = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ram", {ram_cs, ram_we, ram_addr, ram_wdata}, 64'h0);
        chk("rst_ctl", {init_done, m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid}, 64'h0);
        chk("rst_rd0", m0_if.rdata, 64'h0);

        // Cycle 0: m0 requests a write that must wait for init to finish.
        rst = 1'b0;
        m0_if.req = 1'b1; m0_if.we = 1'b1; m0_if.addr = 8'h10; m0_if.wdata = 32'hDEADBEEF;
        #1;
        chk("cyc0", {ram_cs, init_done, m0_if.gnt, m1_if.gnt}, 64'h0);
        for (int n = 0; n < 256; n++) begin
            step();
            chk($sformatf("fill%0d", n),
                {ram_cs, ram_we, ram_addr, ram_wdata, init_done, m0_if.gnt, m1_if.gnt},
                {19'h0, 1'b1, 1'b1, 8'(n), 32'h0, 3'b000});
        end

        // Cycle 257: init done, held write is granted.
        step();
        chk("done257", {init_done, m0_if.gnt, m1_if.gnt}, 64'b110);
        step();
        chk("wr_ram", {ram_cs, ram_we, ram_addr, ram_wdata}, {22'h0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF});
        m0_if.we = 1'b0;
        #1;
        chk("rd_gnt", {m0_if.gnt, m1_if.gnt}, 64'b10);
        step();
        m0_if.req = 1'b0;
        chk("rd_ram", {ram_cs, ram_we, ram_addr}, {54'h0, 1'b1, 1'b0, 8'h10});
        chk("rd_early", m0_if.rvalid, 64'h0);
        step();
        chk("rd_vld", {m0_if.rvalid, m1_if.rvalid}, 64'b10);
        chk("rd_data", m0_if.rdata, 64'hDEADBEEF);
        step();
        chk("rd_end", {m0_if.rvalid, m1_if.rvalid}, 64'b00);
        chk("rd_hold", m0_if.rdata, 64'hDEADBEEF);

        // Port 1 alone: writes then back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            m1_if.req = 1'b1; m1_if.we = 1'b1; m1_if.addr = 8'(i); m1_if.wdata = 32'hA0 + i;
            #1;
            chk($sformatf("p1wr_gnt%0d", i), {m0_if.gnt, m1_if.gnt}, 64'b01);
            step();
        end
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 8'(k);
            end else begin
                m1_if.req = 1'b0;
            end
            #1;
            chk($sformatf("p1rd_gnt%0d", k), m1_if.gnt, (k < 4) ? 64'h1 : 64'h0);
            chk($sformatf("p1rd_vld%0d", k), {m0_if.rvalid, m1_if.rvalid},
                (k >= 2 && k < 6) ? 64'b01 : 64'b00);
            if (k >= 2 && k < 6)
                chk($sformatf("p1rd_dat%0d", k), m1_if.rdata, 64'hA0 + 64'(k - 2));
            step();
        end

        // Both ports contend: strict alternation, m0 first.
        m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 8'h01;
        m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 8'h02;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("rr_gnt%0d", k), {m0_if.gnt, m1_if.gnt},
                (k % 2 == 0) ? 64'b10 : 64'b01);
            if (k >= 1) chk($sformatf("rr_cs%0d", k), ram_cs, 64'h1);
            if (k >= 2) begin
                chk($sformatf("rr_vld%0d", k), {m0_if.rvalid, m1_if.rvalid},
                    (k % 2 == 0) ? 64'b10 : 64'b01);
                chk($sformatf("rr_dat%0d", k),
                    (k % 2 == 0) ? m0_if.rdata : m1_if.rdata,
                    (k % 2 == 0) ? 64'hA1 : 64'hA2);
            end
            step();
        end
        m0_if.req = 1'b0;
        m1_if.req = 1'b0;
        step();
        step();

        // Reset during the RAM cycle of a read drops the response.
        m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 8'h10;
        #1;
        chk("rst_rd_gnt", m0_if.gnt, 64'h1);
        step();
        m0_if.req = 1'b0;
        rst = 1'b1;
        chk("rst_rd_ram", {ram_cs, ram_we, ram_addr}, {54'h0, 1'b1, 1'b0, 8'h10});
        step();
        chk("rst2_ram", {ram_cs, ram_we, ram_addr, ram_wdata}, 64'h0);
        chk("rst2_ctl", {init_done, m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid}, 64'h0);
        chk("rst2_rd0", m0_if.rdata, 64'h0);
        rst = 1'b0;
        step();
        chk("refill0", {ram_cs, ram_we, ram_addr, m0_if.rvalid}, {53'h0, 1'b1, 1'b1, 8'h00, 1'b0});
        step();
        chk("refill1", {ram_cs, ram_we, ram_addr}, {54'h0, 1'b1, 1'b1, 8'h01});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
